// File: rtl/ovi_wb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : ovi_wb_slave_mem
// Brief    : Wishbone B3 slave memory with byte-lane writes, classic cycles
//            with wait states, and registered-feedback linear/wrap bursts.
// Revision : 1.0  initial release
// ============================================================================
module ovi_wb_slave_mem #(
  parameter int unsigned          WB_ADDR_W   = 32,
  parameter int unsigned          WB_DATA_W   = 32,
  parameter int unsigned          MEM_AW      = 10,
  parameter logic [WB_ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned          WAIT_STATES = 0
) (
  input  logic                 wb_clk,
  input  logic                 wb_resetn,
  input  logic [WB_ADDR_W-1:0] wb_adr_i,
  input  logic [WB_DATA_W-1:0] wb_dat_i,
  output logic [WB_DATA_W-1:0] wb_dat_o,
  input  logic [3:0]           wb_sel_i,
  input  logic                 wb_we_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_cyc_i,
  input  logic [2:0]           wb_cti_i,
  input  logic [1:0]           wb_bte_i,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic                 wb_rty_o
);

  localparam int unsigned c_depth     = 1 << MEM_AW;
  localparam int unsigned c_tag_lo    = MEM_AW + 2;
  localparam logic [2:0]  c_ws_last   = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);
  localparam logic [2:0]  c_cti_burst = 3'b010;
  localparam logic [2:0]  c_cti_end   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT        = 3'd1,
    S_CLASSIC_ACK = 3'd2,
    S_BURST       = 3'd3,
    S_GAP         = 3'd4
  } state_t;

  state_t               state_q;
  logic [2:0]           wcnt_q;
  logic [MEM_AW-1:0]    idx_q;
  logic [1:0]           bte_q;
  logic                 we_q;
  logic                 rng_q;
  logic                 burst_q;
  logic                 ack_q;
  logic                 err_q;
  logic [WB_DATA_W-1:0] dat_q;
  logic [WB_DATA_W-1:0] mem_q [c_depth];

  logic [MEM_AW-1:0]    w_req_idx;
  logic                 w_req_rng;
  logic                 w_req_burst;
  logic                 w_req;
  logic [MEM_AW-1:0]    w_mask;
  logic [MEM_AW-1:0]    idx_d;
  logic [MEM_AW-1:0]    w_go_idx;
  logic                 w_go_rng;
  logic                 w_go_burst;
  logic                 w_enter;
  logic                 w_beat;
  logic                 w_unused;

  assign w_req_idx   = wb_adr_i[MEM_AW+1:2];
  assign w_req_rng   = (wb_adr_i[WB_ADDR_W-1:c_tag_lo] == BASE_ADDR[WB_ADDR_W-1:c_tag_lo]);
  assign w_req_burst = (wb_cti_i == c_cti_burst);
  assign w_req       = wb_cyc_i & wb_stb_i;
  assign w_unused    = ^wb_adr_i[1:0];

  // Wrap modes pin the index bits above the wrap boundary; linear lets all bits roll.
  always_comb begin
    w_mask = '1;
    case (bte_q)
      2'b01:   w_mask = MEM_AW'(3);
      2'b10:   w_mask = MEM_AW'(7);
      2'b11:   w_mask = MEM_AW'(15);
      default: w_mask = '1;
    endcase
  end

  assign idx_d = (idx_q & ~w_mask) | ((idx_q + MEM_AW'(1)) & w_mask);

  // From IDLE the termination uses the live request; from WAIT the latched one.
  assign w_go_idx   = (state_q == S_IDLE) ? w_req_idx   : idx_q;
  assign w_go_rng   = (state_q == S_IDLE) ? w_req_rng   : rng_q;
  assign w_go_burst = (state_q == S_IDLE) ? w_req_burst : burst_q;
  assign w_enter    = ((state_q == S_IDLE) && w_req && (WAIT_STATES == 0)) ||
                      ((state_q == S_WAIT) && wb_cyc_i && (wcnt_q == c_ws_last));

  assign wb_ack_o = ack_q & ((state_q != S_BURST) | (wb_cyc_i & wb_stb_i));
  assign wb_err_o = err_q;
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = dat_q;
  assign w_beat   = wb_cyc_i & wb_stb_i & wb_ack_o;

  always_ff @(posedge wb_clk or negedge wb_resetn) begin
    if (!wb_resetn) begin
      state_q <= S_IDLE;
      wcnt_q  <= 3'd0;
      idx_q   <= '0;
      bte_q   <= 2'b00;
      we_q    <= 1'b0;
      rng_q   <= 1'b0;
      burst_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_req) begin
            idx_q   <= w_req_idx;
            rng_q   <= w_req_rng;
            we_q    <= wb_we_i;
            bte_q   <= wb_bte_i;
            burst_q <= w_req_burst;
            wcnt_q  <= 3'd0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!wb_cyc_i) state_q <= S_IDLE;
          else           wcnt_q  <= wcnt_q + 3'd1;
        end
        S_CLASSIC_ACK: state_q <= wb_cyc_i ? S_GAP : S_IDLE;
        S_BURST: begin
          if (!wb_cyc_i) begin
            state_q <= S_IDLE;
          end else if (w_beat) begin
            if (wb_cti_i == c_cti_end) begin
              state_q <= S_GAP;
            end else begin
              ack_q <= 1'b1;
              idx_q <= idx_d;
              dat_q <= mem_q[idx_d];
            end
          end else begin
            ack_q <= 1'b1;
          end
        end
        S_GAP:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      // Later assignment wins: entering the termination state overrides the above.
      if (w_enter) begin
        state_q <= (w_go_rng && w_go_burst) ? S_BURST : S_CLASSIC_ACK;
        ack_q   <= w_go_rng;
        err_q   <= ~w_go_rng;
        dat_q   <= mem_q[w_go_idx];
      end
    end
  end

  always_ff @(posedge wb_clk) begin
    if (w_beat && we_q) begin
      for (int k = 0; k < 4; k++) begin
        if (wb_sel_i[k]) mem_q[idx_q][8*k +: 8] <= wb_dat_i[8*k +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ovi_wb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_ovi_wb_slave_mem
// Brief    : Directed bench for ovi_wb_slave_mem (WAIT_STATES 0 and 3 instances).
// Revision : 1.0  initial release
// ============================================================================
module tb_ovi_wb_slave_mem;

  typedef struct packed {
    logic        tgt;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic        we, stb, cyc, tgt;
  logic [2:0]  cti;
  logic [1:0]  bte;

  logic [31:0] rdat0, rdat3, rdat;
  logic        ack0, err0, rty0, ack3, err3, rty3, ack, err;

  int n_pass  = 0;
  int n_total = 0;

  vec_t        vecs [18];
  logic [31:0] wexp [4];
  logic [31:0] bdat [4];

  always #5 clk = ~clk;

  assign ack  = tgt ? ack3  : ack0;
  assign err  = tgt ? err3  : err0;
  assign rdat = tgt ? rdat3 : rdat0;

  ovi_wb_slave_mem #(.WAIT_STATES(0)) dut0 (
    .wb_clk(clk), .wb_resetn(resetn), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(rdat0),
    .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb & ~tgt), .wb_cyc_i(cyc & ~tgt),
    .wb_cti_i(cti), .wb_bte_i(bte), .wb_ack_o(ack0), .wb_err_o(err0), .wb_rty_o(rty0)
  );

  ovi_wb_slave_mem #(.WAIT_STATES(3)) dut3 (
    .wb_clk(clk), .wb_resetn(resetn), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(rdat3),
    .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb & tgt), .wb_cyc_i(cyc & tgt),
    .wb_cti_i(cti), .wb_bte_i(bte), .wb_ack_o(ack3), .wb_err_o(err3), .wb_rty_o(rty3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Starts just after a rising edge; ends just after the edge that returns the slave to IDLE.
  task automatic classic(input vec_t v, input string tag);
    int n;
    tgt = v.tgt; adr = v.adr; dat_w = v.dat; sel = v.sel; we = v.we;
    cti = 3'b000; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(ack | err) && n < 16);
    check({tag, " latency"}, 32'(n), v.tgt ? 32'd4 : 32'd1);
    check({tag, " err"}, {31'b0, err}, {31'b0, v.exp_err});
    check({tag, " ack"}, {31'b0, ack}, {31'b0, ~v.exp_err});
    if (!v.we && !v.exp_err) check({tag, " rdata"}, rdat, v.exp_rd);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    #1;
    check({tag, " gap"}, {30'b0, ack, err}, 32'd0);
    @(posedge clk); #1;
  endtask

  function automatic vec_t mk(input logic t, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s,
                              input logic e, input logic [31:0] r);
    return '{tgt: t, we: w, adr: a, dat: d, sel: s, exp_err: e, exp_rd: r};
  endfunction

  initial begin
    vecs[0]  = mk(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0);
    vecs[1]  = mk(0, 0, 32'h0000_0010, 32'h0,         4'hF, 0, 32'hDEAD_BEEF);
    vecs[2]  = mk(0, 1, 32'h0000_0020, 32'h1122_3344, 4'hF, 0, 32'h0);
    vecs[3]  = mk(0, 1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 0, 32'h0);
    vecs[4]  = mk(0, 0, 32'h0000_0020, 32'h0,         4'hF, 0, 32'h11BB_33DD);
    vecs[5]  = mk(0, 0, 32'h0000_0023, 32'h0,         4'hF, 0, 32'h11BB_33DD);
    vecs[6]  = mk(0, 1, 32'h0000_0030, 32'h0,         4'hF, 0, 32'h0);
    vecs[7]  = mk(0, 1, 32'h0000_0034, 32'h1,         4'hF, 0, 32'h0);
    vecs[8]  = mk(0, 1, 32'h0000_0038, 32'h2,         4'hF, 0, 32'h0);
    vecs[9]  = mk(0, 1, 32'h0000_003C, 32'h3,         4'hF, 0, 32'h0);
    vecs[10] = mk(0, 1, 32'h0000_0088, 32'h5A5A_5A5A, 4'hF, 0, 32'h0);
    vecs[11] = mk(0, 1, 32'h0000_1010, 32'hFFFF_FFFF, 4'hF, 1, 32'h0);
    vecs[12] = mk(0, 0, 32'h0000_0010, 32'h0,         4'hF, 0, 32'hDEAD_BEEF);
    vecs[13] = mk(0, 0, 32'hFFFF_F010, 32'h0,         4'hF, 1, 32'h0);
    vecs[14] = mk(1, 1, 32'h0000_0010, 32'hCAFE_F00D, 4'hF, 0, 32'h0);
    vecs[15] = mk(1, 0, 32'h0000_0010, 32'h0,         4'hF, 0, 32'hCAFE_F00D);
    vecs[16] = mk(1, 1, 32'h0000_1010, 32'h1234_5678, 4'hF, 1, 32'h0);
    vecs[17] = mk(1, 0, 32'h0000_0010, 32'h0,         4'hF, 0, 32'hCAFE_F00D);
    wexp[0] = 32'd2; wexp[1] = 32'd3; wexp[2] = 32'd0; wexp[3] = 32'd1;
    bdat[0] = 32'h0BAD_0000; bdat[1] = 32'h0BAD_1111;
    bdat[2] = 32'h0BAD_2222; bdat[3] = 32'h0BAD_3333;

    resetn = 1'b0; tgt = 1'b0; adr = '0; dat_w = '0; sel = 4'h0;
    we = 1'b0; stb = 1'b0; cyc = 1'b0; cti = 3'b000; bte = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("reset ack0/err0/rty0", {29'b0, ack0, err0, rty0}, 32'd0);
    check("reset dat0", rdat0, 32'd0);
    check("reset ack3/err3/rty3", {29'b0, ack3, err3, rty3}, 32'd0);
    check("reset dat3", rdat3, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++) classic(vecs[i], $sformatf("vec%0d", i));

    // Wrap4 read burst starting at word 0x38.
    tgt = 1'b0; adr = 32'h38; we = 1'b0; sel = 4'hF; cti = 3'b010; bte = 2'b01;
    cyc = 1'b1; stb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("wrap4 ack%0d", k), {31'b0, ack}, 32'd1);
      check($sformatf("wrap4 data%0d", k), rdat, wexp[k]);
      if (k == 3) cti = 3'b111;
    end
    @(posedge clk); #1;
    check("wrap4 end ack", {31'b0, ack}, 32'd0);
    cyc = 1'b0; stb = 1'b0; cti = 3'b000; bte = 2'b00;
    @(posedge clk); #1;

    // Linear write burst at 0x40 with a two-cycle strobe stall after beat 2.
    adr = 32'h40; we = 1'b1; sel = 4'hF; cti = 3'b010; bte = 2'b00; dat_w = bdat[0];
    cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("stall ack beat%0d", k), {31'b0, ack}, 32'd1);
      if (k == 3) cti = 3'b111;
      @(posedge clk); #1;
      if (k < 3) dat_w = bdat[k+1];
      if (k == 1) begin
        stb = 1'b0; #1;
        check("stall ack low 1", {31'b0, ack}, 32'd0);
        @(posedge clk); #1;
        check("stall ack low 2", {31'b0, ack}, 32'd0);
        @(posedge clk); #1;
        stb = 1'b1; #1;
      end
    end
    check("stall end ack", {31'b0, ack}, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++)
      classic(mk(0, 0, 32'h40 + 32'(4*k), 32'h0, 4'hF, 0, bdat[k]), $sformatf("stall rd%0d", k));

    // Reset asserted while the third beat of a write burst is being acked.
    adr = 32'h80; we = 1'b1; sel = 4'hF; cti = 3'b010; bte = 2'b00; dat_w = 32'hE000_0000;
    cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    check("rstb ack beat0", {31'b0, ack}, 32'd1);
    @(posedge clk); #1;
    dat_w = 32'hE111_1111;
    @(posedge clk); #1;
    dat_w = 32'hE222_2222;
    check("rstb ack beat2", {31'b0, ack}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("rstb async ack clear", {31'b0, ack}, 32'd0);
    check("rstb dat cleared", rdat, 32'd0);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; resetn = 1'b1;
    @(posedge clk); #1;
    classic(mk(0, 0, 32'h80, 32'h0, 4'hF, 0, 32'hE000_0000), "rstb rd0");
    classic(mk(0, 0, 32'h84, 32'h0, 4'hF, 0, 32'hE111_1111), "rstb rd1");
    classic(mk(0, 0, 32'h88, 32'h0, 4'hF, 0, 32'h5A5A_5A5A), "rstb rd2");

    check("rty never asserted", {30'b0, rty0, rty3}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
